// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
//
// Pipeline register between instruction fetch and decode for a 16-bit ISA
// with optional two-word instructions (opcode word followed by an immediate
// word). An opcode word whose masked bits match IMM_MATCH is parked in a
// pending register until its immediate arrives. Then both words are presented
// to decode together, with the PC of the opcode word.
//
// Optional feature: define IF_ID_BUBBLE_CNT_EN to build a saturating counter
// of bubble cycles. These are cycles where out_valid is registered low because
// of a flush, a missing input, or an opcode waiting for its immediate. When
// the macro is undefined, bubble_cnt is tied to zero.
//
// Parameters
//   ADDR_W    : PC width
//   IMM_MASK  : opcode bits examined to detect a two-word instruction
//   IMM_MATCH : value of the masked bits that marks a two-word instruction
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   instr_in    : word from instruction memory
//   pc_in       : address of instr_in
//   in_valid    : instr_in/pc_in valid this cycle
//   stall       : decode hazard, hold all state
//   flush       : branch taken, discard contents
//   instr_out   : instruction to decode
//   imm_out     : immediate word to decode
//   pc_out      : PC of instr_out (first word)
//   out_valid   : bundle valid to decode
//   imm_valid   : imm_out carries an immediate
//   imm_pending : waiting for the immediate word
//   bubble_cnt  : bubble counter (zero unless IF_ID_BUBBLE_CNT_EN)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
// state   | meaning
// --------+------------------------------------------------------------------
// S_FIRST | next accepted word is an opcode
// S_IMM   | opcode parked in pending regs; next accepted word is its immediate
// -----------------------------------------------------------------------------
module if_id_buffer #(
    parameter int          ADDR_W    = 32,
    parameter logic [15:0] IMM_MASK  = 16'hC000,
    parameter logic [15:0] IMM_MATCH = 16'hC000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [15:0]       instr_out,
    output logic [15:0]       imm_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              out_valid,
    output logic              imm_valid,
    output logic              imm_pending,
    output logic [15:0]       bubble_cnt
);

    typedef enum logic {
        S_FIRST = 1'b0,
        S_IMM   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_pend_instr;
    logic [15:0]       w_pend_instr_nxt;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [ADDR_W-1:0] w_pend_pc_nxt;
    logic [15:0]       r_instr_out;
    logic [15:0]       w_instr_out_nxt;
    logic [15:0]       r_imm_out;
    logic [15:0]       w_imm_out_nxt;
    logic [ADDR_W-1:0] r_pc_out;
    logic [ADDR_W-1:0] w_pc_out_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic              r_imm_valid;
    logic              w_imm_valid_nxt;
    logic              w_needs_imm;

    // Only meaningful for an opcode word; the immediate word is never tested.
    assign w_needs_imm = ((instr_in & IMM_MASK) == IMM_MATCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FIRST;
            r_pend_instr <= '0;
            r_pend_pc    <= '0;
            r_instr_out  <= '0;
            r_imm_out    <= '0;
            r_pc_out     <= '0;
            r_out_valid  <= 1'b0;
            r_imm_valid  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_instr <= w_pend_instr_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_instr_out  <= w_instr_out_nxt;
            r_imm_out    <= w_imm_out_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_imm_valid  <= w_imm_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pend_instr_nxt = r_pend_instr;
        w_pend_pc_nxt    = r_pend_pc;
        w_instr_out_nxt  = r_instr_out;
        w_imm_out_nxt    = r_imm_out;
        w_pc_out_nxt     = r_pc_out;
        w_out_valid_nxt  = r_out_valid;
        w_imm_valid_nxt  = r_imm_valid;

        if (flush) begin
            // pc_out is left as-is; it is meaningless while out_valid is low.
            w_state_nxt      = S_FIRST;
            w_pend_instr_nxt = '0;
            w_pend_pc_nxt    = '0;
            w_instr_out_nxt  = 16'h0000;
            w_imm_out_nxt    = '0;
            w_out_valid_nxt  = 1'b0;
            w_imm_valid_nxt  = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (!in_valid) begin
            w_out_valid_nxt = 1'b0;
            w_imm_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_FIRST: begin
                    if (w_needs_imm) begin
                        w_pend_instr_nxt = instr_in;
                        w_pend_pc_nxt    = pc_in;
                        w_out_valid_nxt  = 1'b0;
                        w_imm_valid_nxt  = 1'b0;
                        w_state_nxt      = S_IMM;
                    end else begin
                        w_instr_out_nxt = instr_in;
                        w_pc_out_nxt    = pc_in;
                        w_imm_out_nxt   = '0;
                        w_out_valid_nxt = 1'b1;
                        w_imm_valid_nxt = 1'b0;
                    end
                end
                S_IMM: begin
                    w_instr_out_nxt = r_pend_instr;
                    w_pc_out_nxt    = r_pend_pc;
                    w_imm_out_nxt   = instr_in;
                    w_out_valid_nxt = 1'b1;
                    w_imm_valid_nxt = 1'b1;
                    w_state_nxt     = S_FIRST;
                end
                default: begin
                    w_state_nxt = S_FIRST;
                end
            endcase
        end
    end

`ifdef IF_ID_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;
    logic        w_bubble_inc;

    // Stall and reset cycles are not counted as bubbles.
    assign w_bubble_inc = flush ||
                          (!stall && (!in_valid || (r_state == S_FIRST && w_needs_imm)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble_inc && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`else
    assign bubble_cnt = 16'h0000;
`endif

    assign instr_out   = r_instr_out;
    assign imm_out     = r_imm_out;
    assign pc_out      = r_pc_out;
    assign out_valid   = r_out_valid;
    assign imm_valid   = r_imm_valid;
    assign imm_pending = (r_state == S_IMM);

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr_in;
    logic [31:0] pc_in;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [15:0] instr_out;
    logic [15:0] imm_out;
    logic [31:0] pc_out;
    logic        out_valid;
    logic        imm_valid;
    logic        imm_pending;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: pending opcode kept as a queue of {pc, word}
    logic [15:0] m_instr, m_imm;
    logic [31:0] m_pc;
    logic        m_ov, m_iv;
    logic [47:0] m_pend[$];
    int unsigned m_bub;

    always #5 clk = ~clk;

    if_id_buffer dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .instr_out(instr_out), .imm_out(imm_out), .pc_out(pc_out),
        .out_valid(out_valid), .imm_valid(imm_valid),
        .imm_pending(imm_pending), .bubble_cnt(bubble_cnt)
    );

    function automatic logic [15:0] exp_bub();
`ifdef IF_ID_BUBBLE_CNT_EN
        return m_bub[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    // Advance the model by one cycle from the current inputs, then clock the DUT.
    task automatic step();
        logic [47:0] p;
        if (rst) begin
            m_instr = 0; m_imm = 0; m_pc = 0; m_ov = 0; m_iv = 0;
            m_pend.delete(); m_bub = 0;
        end else if (flush) begin
            m_ov = 0; m_iv = 0; m_instr = 0; m_imm = 0; m_pend.delete();
            if (m_bub < 65535) m_bub++;
        end else if (stall) begin
        end else if (!in_valid) begin
            m_ov = 0; m_iv = 0;
            if (m_bub < 65535) m_bub++;
        end else if (m_pend.size() != 0) begin
            p = m_pend.pop_front();
            m_instr = p[15:0]; m_pc = p[47:16]; m_imm = instr_in;
            m_ov = 1; m_iv = 1;
        end else if ((instr_in & 16'hC000) == 16'hC000) begin
            m_pend.push_back({pc_in, instr_in});
            m_ov = 0; m_iv = 0;
            if (m_bub < 65535) m_bub++;
        end else begin
            m_instr = instr_in; m_pc = pc_in; m_imm = 0; m_ov = 1; m_iv = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] w, input logic [31:0] pc);
        in_valid = v; instr_in = w; pc_in = pc;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; flush = 0; drive(0, 16'h0, 32'h0);
        step(); step();
        rst = 0;
        checks++;
        if ({out_valid, imm_valid, imm_pending, instr_out, imm_out, pc_out, bubble_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got ov=%b iv=%b ip=%b instr=%h imm=%h pc=%h bub=%h, expected all zero",
                     out_valid, imm_valid, imm_pending, instr_out, imm_out, pc_out, bubble_cnt);
        end
    endtask

    task automatic test_single_word();
        drive(1, 16'h1234, 32'h20); step();
        checks++;
        if ({out_valid, imm_valid, instr_out, pc_out} !== {1'b1, 1'b0, 16'h1234, 32'h20}) begin
            errors++;
            $display("FAIL single_word: got ov=%b iv=%b instr=%h pc=%h, expected 1 0 1234 00000020",
                     out_valid, imm_valid, instr_out, pc_out);
        end
    endtask

    task automatic test_two_word();
        drive(1, 16'hC105, 32'h21); step();
        checks++;
        if ({out_valid, imm_pending} !== 2'b01) begin
            errors++;
            $display("FAIL two_word_first: got ov=%b ip=%b, expected 0 1", out_valid, imm_pending);
        end
        drive(1, 16'hBEEF, 32'h22); step();
        checks++;
        if ({out_valid, imm_valid, imm_pending, instr_out, imm_out, pc_out} !==
            {1'b1, 1'b1, 1'b0, 16'hC105, 16'hBEEF, 32'h21}) begin
            errors++;
            $display("FAIL two_word_second: got ov=%b iv=%b ip=%b instr=%h imm=%h pc=%h, expected 1 1 0 c105 beef 00000021",
                     out_valid, imm_valid, imm_pending, instr_out, imm_out, pc_out);
        end
    endtask

    task automatic test_stall();
        drive(1, 16'h1234, 32'h40); step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'($urandom), $urandom);
            step();
            checks++;
            if ({out_valid, imm_valid, instr_out, pc_out, imm_out} !== {1'b1, 1'b0, 16'h1234, 32'h40, 16'h0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got ov=%b iv=%b instr=%h pc=%h imm=%h, expected 1 0 1234 00000040 0000",
                         i, out_valid, imm_valid, instr_out, pc_out, imm_out);
            end
        end
        stall = 0;
        drive(1, 16'h0042, 32'h41); step();
        checks++;
        if ({out_valid, instr_out, pc_out} !== {1'b1, 16'h0042, 32'h41}) begin
            errors++;
            $display("FAIL stall_release: got ov=%b instr=%h pc=%h, expected 1 0042 00000041",
                     out_valid, instr_out, pc_out);
        end
    endtask

    task automatic test_flush_in_imm();
        drive(1, 16'hC105, 32'h50); step();
        flush = 1; stall = 1; drive(1, 16'hBEEF, 32'h51); step();
        flush = 0; stall = 0;
        checks++;
        if ({out_valid, imm_valid, instr_out, imm_out, imm_pending} !== {1'b0, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL flush_stall: got ov=%b iv=%b instr=%h imm=%h ip=%b, expected 0 0 0000 0000 0",
                     out_valid, imm_valid, instr_out, imm_out, imm_pending);
        end
        drive(1, 16'hC000, 32'h60); step();
        checks++;
        if ({out_valid, imm_pending} !== 2'b01) begin
            errors++;
            $display("FAIL flush_then_opcode: got ov=%b ip=%b, expected 0 1", out_valid, imm_pending);
        end
        drive(1, 16'h7777, 32'h61); step();
        checks++;
        if ({out_valid, imm_valid, instr_out, imm_out, pc_out} !== {1'b1, 1'b1, 16'hC000, 16'h7777, 32'h60}) begin
            errors++;
            $display("FAIL flush_then_pair: got ov=%b iv=%b instr=%h imm=%h pc=%h, expected 1 1 c000 7777 00000060",
                     out_valid, imm_valid, instr_out, imm_out, pc_out);
        end
    endtask

    task automatic test_reset_mid_imm();
        drive(1, 16'hC105, 32'h70); step();
        rst = 1; drive(1, 16'hBEEF, 32'h71); step();
        rst = 0;
        checks++;
        if ({out_valid, imm_valid, imm_pending, instr_out, imm_out, pc_out, bubble_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid_imm: got ov=%b iv=%b ip=%b instr=%h imm=%h pc=%h bub=%h, expected all zero",
                     out_valid, imm_valid, imm_pending, instr_out, imm_out, pc_out, bubble_cnt);
        end
        drive(1, 16'h0001, 32'h72); step();
        checks++;
        if ({out_valid, imm_valid, instr_out, pc_out} !== {1'b1, 1'b0, 16'h0001, 32'h72}) begin
            errors++;
            $display("FAIL after_reset_word: got ov=%b iv=%b instr=%h pc=%h, expected 1 0 0001 00000072",
                     out_valid, imm_valid, instr_out, pc_out);
        end
    endtask

    task automatic test_bubble_cnt();
        logic [15:0] exp5;
`ifdef IF_ID_BUBBLE_CNT_EN
        exp5 = 16'd5;
`else
        exp5 = 16'd0;
`endif
        rst = 1; drive(0, 16'h0, 32'h0); step(); rst = 0;
        for (int i = 0; i < 5; i++) step();
        stall = 1;
        step(); step();
        stall = 0;
        checks++;
        if (bubble_cnt !== exp5) begin
            errors++;
            $display("FAIL bubble_cnt: got %0d, expected %0d", bubble_cnt, exp5);
        end
    endtask

    task automatic test_random();
        rst = 1; drive(0, 16'h0, 32'h0); step(); rst = 0;
        for (int n = 0; n < 2000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 19) == 0);
            stall = ($urandom_range(0, 5) == 0);
            drive(($urandom_range(0, 3) != 0), 16'($urandom), $urandom);
            step();
            checks++;
            if ({out_valid, imm_valid, imm_pending} !== {m_ov, m_iv, (m_pend.size() != 0)}) begin
                errors++;
                $display("FAIL rand_flags[%0d]: got ov=%b iv=%b ip=%b, expected %b %b %b",
                         n, out_valid, imm_valid, imm_pending, m_ov, m_iv, (m_pend.size() != 0));
            end
            checks++;
            if ({instr_out, imm_out, pc_out} !== {m_instr, m_imm, m_pc}) begin
                errors++;
                $display("FAIL rand_data[%0d]: got instr=%h imm=%h pc=%h, expected %h %h %h",
                         n, instr_out, imm_out, pc_out, m_instr, m_imm, m_pc);
            end
            checks++;
            if (bubble_cnt !== exp_bub()) begin
                errors++;
                $display("FAIL rand_bubble[%0d]: got %0d, expected %0d", n, bubble_cnt, exp_bub());
            end
        end
        rst = 0; flush = 0; stall = 0;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; in_valid = 0; instr_in = 0; pc_in = 0;
        m_instr = 0; m_imm = 0; m_pc = 0; m_ov = 0; m_iv = 0; m_bub = 0;
        #2;
        test_reset();
        test_single_word();
        test_two_word();
        test_stall();
        test_flush_in_imm();
        test_reset_mid_imm();
        test_bubble_cnt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning PC width.
REQ-002 SHALL have parameter IMM_MASK, default 16'hC000, meaning opcode bits tested for a two-word instruction.
REQ-003 SHALL have parameter IMM_MATCH, default 16'hC000; a word needs an immediate when (word & IMM_MASK) == IMM_MATCH.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port instr_in, input, 16, word from instruction memory.
REQ-007 SHALL have port pc_in, input, ADDR_W, address of instr_in.
REQ-008 SHALL have port in_valid, input, 1, instr_in/pc_in valid this cycle.
REQ-009 SHALL have port stall, input, 1, decode hazard; hold all state.
REQ-010 SHALL have port flush, input, 1, branch taken; discard contents.
REQ-011 SHALL have port instr_out, output, 16, instruction to decode.
REQ-012 SHALL have port imm_out, output, 16, immediate word to decode.
REQ-013 SHALL have port pc_out, output, ADDR_W, PC of instr_out (first word).
REQ-014 SHALL have port out_valid, output, 1, bundle valid to decode.
REQ-015 SHALL have port imm_valid, output, 1, imm_out carries an immediate.
REQ-016 SHALL have port imm_pending, output, 1, high while in state S_IMM.
REQ-017 SHALL have port bubble_cnt, output, 16, bubble counter (see Configuration).

Function
REQ-018 SHALL implement two states: S_FIRST (expect opcode word), S_IMM (expect immediate word); imm_pending = (state == S_IMM).
REQ-019 Priority per cycle SHALL be rst > flush > stall > in_valid.
REQ-020 S_FIRST, accepted word without immediate: instr_out<=instr_in, pc_out<=pc_in, imm_out<=0, out_valid<=1, imm_valid<=0; stay S_FIRST (latency 1 cycle).
REQ-021 S_FIRST, accepted word needing immediate: word and pc_in SHALL be captured into internal pending registers, out_valid<=0, go S_IMM.
REQ-022 S_IMM, accepted word: instr_out<=pending word, pc_out<=pending PC, imm_out<=instr_in, out_valid<=1, imm_valid<=1, go S_FIRST; the immediate word SHALL never be tested against IMM_MASK.
REQ-023 in_valid=0, no stall/flush: out_valid<=0, imm_valid<=0; state and pending registers held (bubble, S_IMM waits indefinitely).
REQ-024 stall=1 (no flush): state, pending and all outputs held unchanged; instr_in ignored (upstream holds its PC).
REQ-025 flush=1: out_valid<=0, imm_valid<=0, instr_out<=16'h0000 (NOP), imm_out<=0, pending cleared, state<=S_FIRST, regardless of stall or in_valid; input that cycle discarded.
REQ-026 Outputs SHALL be registered only; no combinational path from any input to any output.

Reset
REQ-027 On rst=1 at a clock edge: state<=S_FIRST, instr_out<=0, imm_out<=0, pc_out<=0, out_valid<=0, imm_valid<=0, pending cleared, bubble_cnt<=0.
REQ-028 Reset asserted mid two-word instruction SHALL drop the pending word; first accepted word after reset is treated as an opcode.

Configuration
REQ-029 Macro IF_ID_BUBBLE_CNT_EN defined: bubble_cnt SHALL increment by 1 each cycle out_valid is registered 0 for a reason other than stall or rst (flush, in_valid=0, or S_FIRST->S_IMM), saturating at 16'hFFFF.
REQ-030 Macro IF_ID_BUBBLE_CNT_EN undefined: counter logic SHALL be absent and bubble_cnt tied to 16'h0000; all other behaviour identical.

Verification
REQ-031 Reset, then in_valid=1, instr_in=16'h1234, pc_in=32'h20 -> next cycle out_valid=1, instr_out=16'h1234, pc_out=32'h20, imm_valid=0.
REQ-032 instr_in=16'hC105 @pc 32'h21 then 16'hBEEF @pc 32'h22 -> first cycle out_valid=0, imm_pending=1; second cycle out_valid=1, instr_out=16'hC105, imm_out=16'hBEEF, pc_out=32'h21, imm_valid=1.
REQ-033 Bundle 16'h1234 at outputs, stall=1 for 3 cycles with changing instr_in -> outputs unchanged for 3 cycles; first word after stall release appears next cycle.
REQ-034 In S_IMM after 16'hC105, assert flush=1 and stall=1 together -> next cycle out_valid=0, instr_out=16'h0000, imm_pending=0; following 16'hC000 treated as opcode (imm_pending=1).
REQ-035 Mid S_IMM, rst=1 one cycle -> all outputs 0, imm_pending=0, bubble_cnt=0; then 16'h0001 -> out_valid=1, imm_valid=0.
REQ-036 With IF_ID_BUBBLE_CNT_EN: 5 cycles in_valid=0 then 2 stall cycles -> bubble_cnt=5; without macro bubble_cnt=0 throughout.
